// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between I-cache and D-cache
// line traffic. One line transaction at a time (I read, D read, D write-back),
// fixed memory latency timed by an internal down-counter, round-robin on ties.
//
// Handshake: i_req/d_req are levels held by the cache until it samples its
// ack high; the cache drops req at that same edge. i_ack/d_ack are one-cycle
// completion pulses issued in RESP. There is no back-pressure from memory.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_d;   // 1 = D won the previous arbitration
  logic               owner_d;  // 1 = D owns the current transaction
  logic               pick_d;

  assign dbg_state = state;

  // Arbitration: a lone requester wins; on a tie the side that did not win last time wins
  always_comb begin
    pick_d = d_req & (~i_req | ~last_d);
  end

  // Main FSM: IDLE arbitrates and latches, BUSY times the access, RESP pulses ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d  <= pick_d;
            last_d   <= pick_d;
            grant    <= pick_d ? 2'b10 : 2'b01;
            mem_addr <= pick_d ? d_addr : i_addr;
            if (pick_d) begin
              mem_wdata <= d_wdata;
            end
            mem_we   <= pick_d & d_we;
            mem_en   <= 1'b1;
            busy     <= 1'b1;
            cnt      <= CNT_W'(MEM_LAT - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            // mem_we still holds the latched direction on this final cycle
            if (!mem_we) begin
              if (owner_d) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            if (owner_d) begin
              d_ack <= 1'b1;
            end else begin
              i_ack <= 1'b1;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction scoreboard.
// Main instance uses MEM_LAT=4; a second instance uses MEM_LAT=1.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int LAT    = 4;
  localparam int EW     = 2 + ADDR_W + LINE_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (MEM_LAT=4) ----------------
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              mem_en, mem_we, i_ack, d_ack, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata, i_rdata, d_rdata;
  logic [1:0]        grant, dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .i_ack(i_ack), .i_rdata(i_rdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (MEM_LAT=1) ----------------
  logic              l1_i_req;
  logic [ADDR_W-1:0] l1_i_addr;
  logic              l1_mem_en, l1_mem_we, l1_i_ack, l1_d_ack, l1_busy;
  logic [ADDR_W-1:0] l1_mem_addr;
  logic [LINE_W-1:0] l1_mem_wdata, l1_mem_rdata, l1_i_rdata, l1_d_rdata;
  logic [1:0]        l1_grant, l1_dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(l1_i_addr),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata),
    .i_ack(l1_i_ack), .i_rdata(l1_i_rdata), .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .grant(l1_grant), .busy(l1_busy), .dbg_state(l1_dbg_state)
  );

  // ---------------- memory model ----------------
  // Line content per address; data is only valid on the last cycle of an access.
  function automatic logic [LINE_W-1:0] line_for(input logic [ADDR_W-1:0] a);
    if (a == 32'h40) return {16{8'hA5}};
    return {a, ~a, a ^ 32'h5A5A5A5A, 32'hC0FFEE00};
  endfunction

  int en_run = 0;
  always @(posedge clk) en_run <= mem_en ? en_run + 1 : 0;
  assign mem_rdata    = (mem_en && en_run == LAT - 1) ? line_for(mem_addr) : {LINE_W{1'b1}};
  assign l1_mem_rdata = l1_mem_en ? line_for(l1_mem_addr) : {LINE_W{1'b1}};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]     exp_q[$];
  logic [LINE_W-1:0] m_i_rdata = '0;
  logic [LINE_W-1:0] m_d_rdata = '0;
  bit                model_last_d = 1'b0;
  int                acks_i = 0, acks_d = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit side, input bit we, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] wd);
    exp_q.push_back({side, we, a, wd});
    model_last_d = side;
  endtask

  // Monitor: checks the memory port against the head transaction and pops on ack
  logic [EW-1:0]     mon_e;
  bit                mon_s, mon_w;
  logic [ADDR_W-1:0] mon_a;
  logic [LINE_W-1:0] mon_d;
  int                run_len = 0;
  bit                prev_en = 1'b0, prev_ack = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_e = (exp_q.size() > 0) ? exp_q[0] : '0;
      {mon_s, mon_w, mon_a, mon_d} = mon_e;
      if (mem_en) begin
        check("mem_en_expected", exp_q.size() > 0, 1);
        check("mem_addr", mem_addr, mon_a);
        check("mem_we", mem_we, mon_w);
        if (mon_w) check("mem_wdata", mem_wdata, mon_d);
        check("grant_busy", grant, mon_s ? 2'b10 : 2'b01);
        check("busy_in_busy", busy, 1);
        check("state_busy", dbg_state, 2'd1);
        run_len++;
      end else begin
        check("mem_we_outside_busy", mem_we, 0);
        if (prev_en) check("busy_length", run_len, LAT);
        run_len = 0;
      end
      if (i_ack || d_ack) begin
        check("ack_expected", exp_q.size() > 0, 1);
        check("ack_single_cycle", prev_ack, 0);
        check("i_ack_owner", i_ack, !mon_s);
        check("d_ack_owner", d_ack, mon_s);
        check("grant_resp", grant, mon_s ? 2'b10 : 2'b01);
        check("busy_resp", busy, 1);
        check("state_resp", dbg_state, 2'd2);
        if (!mon_w) begin
          if (mon_s) m_d_rdata = line_for(mon_a);
          else       m_i_rdata = line_for(mon_a);
        end
        check("i_rdata", i_rdata, m_i_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        if (i_ack) acks_i++;
        if (d_ack) acks_d++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!mem_en) begin
        check("grant_idle", grant, 0);
        check("busy_idle", busy, 0);
      end
      prev_en  = mem_en;
      prev_ack = i_ack || d_ack;
    end else begin
      run_len  = 0;
      prev_en  = 1'b0;
      prev_ack = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for the given side's ack (bounded), then drops req at the next edge.
  task automatic wait_ack(input bit side, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(side ? d_ack : i_ack) && cyc < 100);
    check(side ? "d_ack_seen" : "i_ack_seen", side ? d_ack : i_ack, 1);
    @(posedge clk);
    #1;
    if (side) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  task automatic check_all_zero();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  int c1, c2;
  initial begin
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    l1_i_req = 1'b0; l1_i_addr = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single I read at 0x40
    i_addr = 32'h40; i_req = 1'b1; push(1'b0, 1'b0, 32'h40, '0);
    wait_ack(1'b0, c1);
    check("i_read_latency", c1, LAT + 2);
    check("i_read_data", i_rdata, {16{8'hA5}});
    repeat (2) @(posedge clk);
    #1;

    // Tie: last winner was I, so D goes first, then I
    i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    if (model_last_d) begin
      push(1'b0, 1'b0, 32'h200, '0); push(1'b1, 1'b0, 32'h300, '0);
    end else begin
      push(1'b1, 1'b0, 32'h300, '0); push(1'b0, 1'b0, 32'h200, '0);
    end
    wait_ack(1'b1, c1);
    wait_ack(1'b0, c2);
    check("tie_first_latency", c1, LAT + 2);
    check("tie_total_cycles", c1 + c2, 2 * (LAT + 2));
    repeat (2) @(posedge clk);
    #1;

    // Continuous contention: D, I, D, I
    acks_i = 0; acks_d = 0;
    i_addr = 32'h1000; d_addr = 32'h2000;
    i_req = 1'b1; d_req = 1'b1;
    push(1'b1, 1'b0, 32'h2000, '0); push(1'b0, 1'b0, 32'h1000, '0);
    wait_ack(1'b1, c1);
    @(posedge clk); #1;
    d_addr = 32'h2040; d_req = 1'b1; push(1'b1, 1'b0, 32'h2040, '0);
    wait_ack(1'b0, c1);
    @(posedge clk); #1;
    i_addr = 32'h1040; i_req = 1'b1; push(1'b0, 1'b0, 32'h1040, '0);
    wait_ack(1'b1, c1);
    wait_ack(1'b0, c1);
    repeat (2) @(negedge clk);
    check("contention_acks_i", acks_i, 2);
    check("contention_acks_d", acks_d, 2);
    check("contention_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // D write-back
    d_we = 1'b1; d_addr = 32'h100; d_wdata = {4{32'h12345678}}; d_req = 1'b1;
    push(1'b1, 1'b1, 32'h100, {4{32'h12345678}});
    wait_ack(1'b1, c1);
    d_we = 1'b0; d_wdata = '0;
    check("wb_latency", c1, LAT + 2);
    @(negedge clk);
    check("mem_wdata_hold", mem_wdata, {4{32'h12345678}});
    check("mem_addr_hold", mem_addr, 32'h100);
    @(posedge clk); #1;

    // Reset during the second BUSY cycle
    i_addr = 32'h500; i_req = 1'b1; push(1'b0, 1'b0, 32'h500, '0);
    @(posedge clk);
    @(posedge clk);
    #1 check("pre_reset_busy", mem_en, 1);
    #1;
    reset = 1'b0;
    i_req = 1'b0;
    exp_q.delete();
    m_i_rdata = '0; m_d_rdata = '0; model_last_d = 1'b0;
    #1 check_all_zero();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    @(posedge clk); #1;
    d_addr = 32'h600; d_req = 1'b1; push(1'b1, 1'b0, 32'h600, '0);
    wait_ack(1'b1, c1);
    check("post_reset_latency", c1, LAT + 2);
    @(posedge clk); #1;

    // MEM_LAT=1 instance, request dropped right after grant
    l1_i_addr = 32'h80; l1_i_req = 1'b1;
    @(posedge clk); #1;
    l1_i_req = 1'b0;
    @(negedge clk);
    check("l1_mem_en_busy", l1_mem_en, 1);
    check("l1_grant_busy", l1_grant, 2'b01);
    check("l1_mem_addr", l1_mem_addr, 32'h80);
    check("l1_ack_early", l1_i_ack, 0);
    @(negedge clk);
    check("l1_mem_en_resp", l1_mem_en, 0);
    check("l1_i_ack", l1_i_ack, 1);
    check("l1_i_rdata", l1_i_rdata, line_for(32'h80));
    check("l1_grant_resp", l1_grant, 2'b01);
    @(negedge clk);
    check("l1_ack_once", l1_i_ack, 0);
    check("l1_grant_idle", l1_grant, 0);
    @(negedge clk);
    check("l1_no_regrant", l1_mem_en, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
